// File: rtl/gig_mac_tx_feeder.sv
// Packet FIFO feeding the gigabit MAC TX client with the TEMAC first-byte/ack handshake.
// Define GIG_MAC_TX_CUT_THROUGH_EN for cut-through start with underrun abort; otherwise
// store-and-forward with oversize-frame drop.
module gig_mac_tx_feeder #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned START_THRESH = 64
) (
  input  logic       tx_clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_eop,
  input  logic       in_vld,
  output logic       in_rdy,
  output logic [7:0] mac_tx_data,
  output logic       mac_tx_dvld,
  input  logic       mac_tx_ack,
  output logic       mac_tx_underrun,
  output logic       stat_tx_pkt,
  output logic       stat_tx_drop,
  output logic       stat_tx_underrun
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitAck  = 3'd1;
  localparam logic [2:0] StSend     = 3'd2;
  localparam logic [2:0] StTailDrop = 3'd3;
  localparam logic [2:0] StGap      = 3'd4;

  if (START_THRESH == 0 || START_THRESH >= Depth) begin : g_thresh_range
    $error("START_THRESH must lie in 1 .. 2**ADDR_W-1");
  end

  logic [8:0]      mem [Depth];
  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q, count_q, frame_cnt_q;
  logic [2:0]      state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            dvld_q, dvld_d;
  logic            eop_q, eop_d;
  logic            pkt_q, pkt_d;

  logic            push, pop, flush, full, empty, start;
  logic [8:0]      rd_word;
  logic [7:0]      rd_data;
  logic            rd_eop;

  // Pointers carry a wrap bit, so full is "same slot, opposite lap".
  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}};
  assign empty   = (count_q == '0);
  assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
  assign rd_data = rd_word[7:0];
  assign rd_eop  = rd_word[8];

`ifdef GIG_MAC_TX_CUT_THROUGH_EN
  localparam logic [ADDR_W:0] StartThresh = (ADDR_W + 1)'(START_THRESH);

  logic ur_q, ur_d;

  assign start  = (frame_cnt_q != '0) || (count_q >= StartThresh);
  assign in_rdy = !full;
  assign push   = in_vld && !full;
  assign flush  = 1'b0;

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      ur_q <= 1'b0;
    end else begin
      ur_q <= ur_d;
    end
  end

  assign mac_tx_underrun  = ur_q;
  assign stat_tx_underrun = ur_q;
  assign stat_tx_drop     = 1'b0;
`else
  logic drop_mode_q, drop_pulse_q, drop_end;

  assign start    = (frame_cnt_q != '0);
  // A full FIFO with no complete frame can never drain: discard it and the rest of the frame.
  assign flush    = full && (frame_cnt_q == '0) && (state_q == StIdle) && !drop_mode_q;
  assign in_rdy   = !full || drop_mode_q;
  assign push     = in_vld && in_rdy && !drop_mode_q;
  assign drop_end = drop_mode_q && in_vld && in_eop;

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_mode_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      if (flush) begin
        drop_mode_q <= 1'b1;
      end else if (drop_end) begin
        drop_mode_q <= 1'b0;
      end
      drop_pulse_q <= drop_end;
    end
  end

  assign mac_tx_underrun  = 1'b0;
  assign stat_tx_underrun = 1'b0;
  assign stat_tx_drop     = drop_pulse_q;
`endif

  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {in_eop, in_data};
    end
  end

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (flush) begin
        count_q <= '0;
      end else if (push && !pop) begin
        count_q <= count_q + PtrOne;
      end else if (pop && !push) begin
        count_q <= count_q - PtrOne;
      end
      if ((push && in_eop) && !(pop && rd_eop)) begin
        frame_cnt_q <= frame_cnt_q + PtrOne;
      end else if (!(push && in_eop) && (pop && rd_eop)) begin
        frame_cnt_q <= frame_cnt_q - PtrOne;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dvld_d  = dvld_q;
    eop_d   = eop_q;
    pkt_d   = 1'b0;
    pop     = 1'b0;
`ifdef GIG_MAC_TX_CUT_THROUGH_EN
    ur_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pop     = 1'b1;
          data_d  = rd_data;
          eop_d   = rd_eop;
          dvld_d  = 1'b1;
          state_d = StWaitAck;
        end
      end
      StWaitAck, StSend: begin
        if ((state_q == StSend || mac_tx_ack) && eop_q) begin
          dvld_d  = 1'b0;
          pkt_d   = 1'b1;
          state_d = StGap;
        end else if (state_q == StSend || mac_tx_ack) begin
          if (!empty) begin
            pop     = 1'b1;
            data_d  = rd_data;
            eop_d   = rd_eop;
            state_d = StSend;
          end
`ifdef GIG_MAC_TX_CUT_THROUGH_EN
          else begin
            dvld_d  = 1'b0;
            ur_d    = 1'b1;
            state_d = StTailDrop;
          end
`endif
        end
      end
      StTailDrop: begin
        if (!empty) begin
          pop = 1'b1;
          if (rd_eop) begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      dvld_q  <= 1'b0;
      eop_q   <= 1'b0;
      pkt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dvld_q  <= dvld_d;
      eop_q   <= eop_d;
      pkt_q   <= pkt_d;
    end
  end

  assign mac_tx_data = data_q;
  assign mac_tx_dvld = dvld_q;
  assign stat_tx_pkt = pkt_q;

endmodule
